// File: rtl/button_event_pkg.sv
// Shared board UI package: button FSM encodings and event bundle.
// Later UI blocks import the same state constants.
package button_event_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_LONG  = 2'd2;

  typedef struct packed {
    logic press;
    logic rls;
    logic long_p;
    logic rpt;
  } btn_evt_t;

endpackage

// File: rtl/button_event_if.sv
// Button level in, registered event strobes and held level out.
// master = event generator, slave = button source / event consumer.
interface button_event_if;

  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output long_press,
    output repeat_pulse,
    output held
  );

  modport slave (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press,
    input  repeat_pulse,
    input  held
  );

endinterface

// File: rtl/button_event.sv
// Press / release / long-press / auto-repeat event generator
// fed by a debounced, synchronous button level.
module button_event
  import button_event_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = 12_000_000,
  parameter int unsigned REPEAT_CYCLES = 3_000_000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic           sys_clock,
  input  logic           reset,
  button_event_if.master bus
);

  localparam logic [CNT_W-1:0] LONG_TC =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_TC =
    CNT_W'(REPEAT_CYCLES - 1);

  logic             active;
  logic             prev_q, prev_d;
  logic             armed_q, armed_d;
  logic             held_q, held_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_evt_t         evt_q, evt_d;

  assign active = bus.btn_level ^ ACTIVE_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    evt_d   = '0;
    prev_d  = active;
    armed_d = 1'b1;
    // The first edge after reset only captures prev.
    if (armed_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (active && !prev_q) begin
            evt_d.press = 1'b1;
            held_d      = 1'b1;
            cnt_d       = '0;
            state_d     = ST_PRESS;
          end
        end
        ST_PRESS, ST_LONG: begin
          if (!active) begin
            evt_d.rls = 1'b1;
            held_d    = 1'b0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else if (state_q == ST_PRESS) begin
            if (cnt_q == LONG_TC) begin
              evt_d.long_p = 1'b1;
              cnt_d        = '0;
              state_d      = ST_LONG;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            if (cnt_q == RPT_TC) begin
              evt_d.rpt = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          held_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      held_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      held_q  <= held_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.press_pulse   = evt_q.press;
  assign bus.release_pulse = evt_q.rls;
  assign bus.long_press    = evt_q.long_p;
  assign bus.repeat_pulse  = evt_q.rpt;
  assign bus.held          = held_q;

endmodule
